// File: rtl/axi_wr_slave_ctrl.sv
// AXI4 write-channel slave: accepts one AW burst at a time, generates per-beat byte
// addresses (FIXED/INCR/WRAP), drives a registered memory write port and returns B.
module axi_wr_slave_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [7:0]              awid,
  input  logic [ADD_WIDTH-1:0]    awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [7:0]              bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  output logic                    mem_we,
  output logic [ADD_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb
);

  localparam int         STRB_W   = DATA_WIDTH / 8;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_W));

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // awready/wready/bvalid are registered from the next state, so each changes one
  // cycle after the handshake that moves the FSM.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                 aw_hs, w_hs, b_hs;
  logic [7:0]           id_q, len_q, beat_cnt;
  logic [2:0]           size_q;
  logic [1:0]           burst_q;
  logic [ADD_WIDTH-1:0] cur_addr, wrap_lo, wrap_hi, nxt_addr;
  logic                 err_q, sup_q;
  logic                 last_beat;

  logic [ADD_WIDTH-1:0] aw_s, aw_mask, aw_t;
  logic [ADD_WIDTH-1:0] cur_s;
  logic                 aw_wrap_len_ok, aw_bad;

  assign aw_hs     = awvalid & awready;
  assign w_hs      = wvalid & wready;
  assign b_hs      = bvalid & bready;
  assign last_beat = (beat_cnt == len_q);

  // Decode of the incoming AW request; only meaningful on the AW handshake cycle.
  always_comb begin
    aw_s           = ADD_WIDTH'(1) << awsize;
    aw_mask        = aw_s - ADD_WIDTH'(1);
    aw_t           = (ADD_WIDTH'(awlen) + ADD_WIDTH'(1)) << awsize;
    aw_wrap_len_ok = (awlen == 8'd1) || (awlen == 8'd3) || (awlen == 8'd7) || (awlen == 8'd15);
    aw_bad         = 1'b0;
    if (awburst == 2'b11) aw_bad = 1'b1;
    if (awsize > MAX_SIZE) aw_bad = 1'b1;
    if (awburst == 2'b10 && !aw_wrap_len_ok) aw_bad = 1'b1;
    if (awburst == 2'b10 && ((awaddr & aw_mask) != '0)) aw_bad = 1'b1;
  end

  // Address of the beat after the current one.
  always_comb begin
    cur_s    = ADD_WIDTH'(1) << size_q;
    nxt_addr = cur_addr;
    case (burst_q)
      2'b01:   nxt_addr = (cur_addr & ~(cur_s - ADD_WIDTH'(1))) + cur_s;
      2'b10:   nxt_addr = ((cur_addr + cur_s) == wrap_hi) ? wrap_lo : (cur_addr + cur_s);
      default: nxt_addr = cur_addr;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (aw_hs) state_nxt = DATA;
      DATA:    if (w_hs && last_beat) state_nxt = RESP;
      RESP:    if (b_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state   <= IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
    end else begin
      state   <= state_nxt;
      awready <= (state_nxt == IDLE);
      wready  <= (state_nxt == DATA);
      bvalid  <= (state_nxt == RESP);
    end
  end

  // Burst context. sup_q blocks memory writes for protocol errors; a wlast
  // mismatch only flags err_q and the burst is still written.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      id_q     <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      cur_addr <= '0;
      wrap_lo  <= '0;
      wrap_hi  <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
      sup_q    <= 1'b0;
    end else if (aw_hs) begin
      id_q     <= awid;
      len_q    <= awlen;
      size_q   <= awsize;
      burst_q  <= awburst;
      cur_addr <= awaddr;
      wrap_lo  <= awaddr & ~(aw_t - ADD_WIDTH'(1));
      wrap_hi  <= (awaddr & ~(aw_t - ADD_WIDTH'(1))) + aw_t;
      beat_cnt <= '0;
      err_q    <= aw_bad;
      sup_q    <= aw_bad;
    end else if (w_hs) begin
      cur_addr <= nxt_addr;
      beat_cnt <= beat_cnt + 8'd1;
      if (wlast != last_beat) err_q <= 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      mem_we <= w_hs & ~sup_q;
      if (w_hs && !sup_q) begin
        mem_addr  <= cur_addr;
        mem_wdata <= wdata;
        mem_wstrb <= wstrb;
      end
    end
  end

  assign bid   = bvalid ? id_q : 8'd0;
  assign bresp = (bvalid && err_q) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_axi_wr_slave_ctrl.sv
// Bench for axi_wr_slave_ctrl: directed spec scenarios plus random bursts, all checked
// cycle by cycle against a burst-level model computing addresses in closed form.
module tb_axi_wr_slave_ctrl;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MAX_SIZE = 2;

  logic          clk = 1'b0;
  logic          areset;
  logic [7:0]    awid;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          wlast;
  logic          wvalid;
  logic          wready;
  logic [7:0]    bid;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;

  axi_wr_slave_ctrl #(.DATA_WIDTH(DW), .ADD_WIDTH(AW)) dut (
    .aclk(clk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] beat_addr(input logic [31:0] a0, input int len, input int size,
                                            input logic [1:0] burst, input int i);
    logic [31:0] s, t, lo;
    s  = 32'd1 << size;
    t  = s * 32'(len + 1);
    lo = a0 & ~(t - 32'd1);
    case (burst)
      2'b00:   return a0;
      2'b01:   return (i == 0) ? a0 : ((a0 & ~(s - 32'd1)) + 32'(i) * s);
      default: return lo + ((a0 - lo + 32'(i) * s) % t);
    endcase
  endfunction

  function automatic logic burst_bad(input logic [31:0] a0, input int len, input int size,
                                     input logic [1:0] burst);
    logic [31:0] s;
    s = 32'd1 << size;
    if (burst == 2'b11) return 1'b1;
    if (size > MAX_SIZE) return 1'b1;
    if (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
    if (burst == 2'b10 && (a0 & (s - 32'd1)) != 32'd0) return 1'b1;
    return 1'b0;
  endfunction

  int          m_mode;  // 0 waiting for AW, 1 taking beats, 2 responding
  int          m_beat, m_len, m_size;
  logic [31:0] m_a0;
  logic [1:0]  m_burst;
  logic [7:0]  m_id;
  logic        m_bad, m_err;
  logic        e_awready, e_wready, e_bvalid, e_we;
  logic [7:0]  e_bid;
  logic [1:0]  e_bresp;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_wstrb;

  // Observations for directed literal checks
  logic [AW-1:0] obs_addr[$];
  logic [AW-1:0] exp_q[$];
  int            b_count = 0;
  logic [1:0]    obs_bresp;
  logic [7:0]    obs_bid;

  // ---------------- compare process ----------------
  initial begin
    logic aw_hs, w_hs, b_hs;
    m_mode = 0; m_err = 1'b0; m_bad = 1'b0;
    forever begin
      @(negedge clk);
      if (areset) begin
        chk("reset_outputs", 128'({awready, wready, bvalid, mem_we, bid, bresp, mem_addr, mem_wdata, mem_wstrb}), 128'd0);
        m_mode = 0; m_err = 1'b0;
        e_awready = 1'b0; e_wready = 1'b0; e_bvalid = 1'b0; e_we = 1'b0;
      end else begin
        chk("awready", 128'(awready), 128'(e_awready));
        chk("wready", 128'(wready), 128'(e_wready));
        chk("bvalid", 128'(bvalid), 128'(e_bvalid));
        chk("mem_we", 128'(mem_we), 128'(e_we));
        chk("aw_b_exclusive", 128'(awready & bvalid), 128'd0);
        if (e_we) begin
          chk("mem_addr", 128'(mem_addr), 128'(e_addr));
          chk("mem_wdata", 128'(mem_wdata), 128'(e_wdata));
          chk("mem_wstrb", 128'(mem_wstrb), 128'(e_wstrb));
        end
        if (e_bvalid) begin
          chk("bid", 128'(bid), 128'(e_bid));
          chk("bresp", 128'(bresp), 128'(e_bresp));
        end
        if (mem_we) obs_addr.push_back(mem_addr);
        if (bvalid && bready) begin
          b_count++;
          obs_bresp = bresp;
          obs_bid   = bid;
        end

        // Model step for the coming rising edge
        aw_hs = awvalid && e_awready;
        w_hs  = wvalid && e_wready;
        b_hs  = bready && e_bvalid;
        e_we  = 1'b0;
        case (m_mode)
          0: if (aw_hs) begin
            m_id = awid; m_a0 = awaddr; m_len = int'(awlen); m_size = int'(awsize);
            m_burst = awburst; m_beat = 0;
            m_bad = burst_bad(m_a0, m_len, m_size, m_burst);
            m_err = m_bad;
            m_mode = 1;
          end
          1: if (w_hs) begin
            if (!m_bad) begin
              e_we    = 1'b1;
              e_addr  = beat_addr(m_a0, m_len, m_size, m_burst, m_beat);
              e_wdata = wdata;
              e_wstrb = wstrb;
            end
            if (wlast != (m_beat == m_len)) m_err = 1'b1;
            if (m_beat == m_len) m_mode = 2;
            else m_beat++;
          end
          default: if (b_hs) m_mode = 0;
        endcase
        e_awready = (m_mode == 0);
        e_wready  = (m_mode == 1);
        e_bvalid  = (m_mode == 2);
        e_bid     = m_id;
        e_bresp   = m_err ? 2'b10 : 2'b00;
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic hold_b = 1'b0;

  initial begin
    bready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bready = hold_b ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input logic [7:0] id, input logic [31:0] addr, input int len,
                       input int size, input logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = burst;
    awvalid = 1'b1;
    @(negedge clk);
    while (!awready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("aw_timeout", 128'd1, 128'd0);
    step();
    awvalid = 1'b0;
  endtask

  task automatic do_w(input logic last);
    int n = 0;
    repeat ($urandom_range(0, 2)) step();
    wdata = $urandom; wstrb = 4'($urandom_range(0, 15)); wlast = last;
    wvalid = 1'b1;
    @(negedge clk);
    while (!wready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("w_timeout", 128'd1, 128'd0);
    step();
    wvalid = 1'b0;
  endtask

  task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input int len,
                           input int size, input logic [1:0] burst, input int bad_beat);
    do_aw(id, addr, len, size, burst);
    for (int i = 0; i <= len; i++) do_w((i == len) ^ (i == bad_beat));
  endtask

  task automatic wait_b(input int target);
    int n = 0;
    while (b_count < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (b_count < target) chk("b_timeout", 128'd1, 128'd0);
    step();
  endtask

  task automatic check_obs(input string name);
    chk({name, "_count"}, 128'(obs_addr.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_addr.size(); i++)
      chk({name, "_addr"}, 128'(obs_addr[i]), 128'(exp_q[i]));
    obs_addr.delete();
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int b0;
    int len, size, bad;
    logic [1:0] burst;
    logic [31:0] addr;
    areset = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1 areset = 1'b0;
    step();

    chk("model_wrap_pin", 128'(beat_addr(32'h38, 3, 2, 2'b10, 2)), 128'h30);
    chk("model_incr_pin", 128'(beat_addr(32'h103, 2, 2, 2'b01, 1)), 128'h104);

    // INCR aligned
    obs_addr.delete(); b0 = b_count;
    run_burst(8'h5A, 32'h100, 3, 2, 2'b01, -1);
    wait_b(b0 + 1);
    exp_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
    check_obs("incr");
    chk("incr_bresp", 128'(obs_bresp), 128'd0);
    chk("incr_bid", 128'(obs_bid), 128'h5A);

    // WRAP
    b0 = b_count;
    run_burst(8'h11, 32'h38, 3, 2, 2'b10, -1);
    wait_b(b0 + 1);
    exp_q = '{32'h38, 32'h3C, 32'h30, 32'h34};
    check_obs("wrap");
    chk("wrap_bresp", 128'(obs_bresp), 128'd0);

    // FIXED
    b0 = b_count;
    run_burst(8'h22, 32'h20, 2, 2, 2'b00, -1);
    wait_b(b0 + 1);
    exp_q = '{32'h20, 32'h20, 32'h20};
    check_obs("fixed");

    // INCR unaligned start
    b0 = b_count;
    run_burst(8'h23, 32'h103, 2, 2, 2'b01, -1);
    wait_b(b0 + 1);
    exp_q = '{32'h103, 32'h104, 32'h108};
    check_obs("incr_unaligned");

    // Reserved burst type and oversize beats: consumed, never written
    b0 = b_count;
    run_burst(8'h31, 32'h40, 1, 2, 2'b11, -1);
    wait_b(b0 + 1);
    check_obs("reserved");
    chk("reserved_bresp", 128'(obs_bresp), 128'h2);
    b0 = b_count;
    run_burst(8'h32, 32'h40, 1, 3, 2'b01, -1);
    wait_b(b0 + 1);
    check_obs("oversize");
    chk("oversize_bresp", 128'(obs_bresp), 128'h2);

    // wlast early on beat 1, with B held off for 5 cycles
    hold_b = 1'b1;
    b0 = b_count;
    run_burst(8'h44, 32'h400, 3, 2, 2'b01, 1);
    begin
      int n = 0;
      while (!bvalid && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("hold_bvalid_seen", 128'(bvalid), 128'd1);
    end
    repeat (5) begin
      @(negedge clk);
      chk("hold_bvalid", 128'(bvalid), 128'd1);
      chk("hold_bid", 128'(bid), 128'h44);
      chk("hold_bresp", 128'(bresp), 128'h2);
      chk("hold_awready", 128'(awready), 128'd0);
    end
    hold_b = 1'b0;
    wait_b(b0 + 1);
    exp_q = '{32'h400, 32'h404, 32'h408, 32'h40C};
    check_obs("wlast_err");
    chk("wlast_err_bresp", 128'(obs_bresp), 128'h2);

    // Asynchronous reset in the middle of a long burst
    do_aw(8'h77, 32'h200, 7, 2, 2'b01);
    do_w(1'b0);
    do_w(1'b0);
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    @(posedge clk);
    #3 areset = 1'b1;
    #1 chk("async_reset_outputs", 128'({awready, wready, bvalid, mem_we, bid, bresp, mem_addr, mem_wdata, mem_wstrb}), 128'd0);
    wvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;
    obs_addr.delete();
    b0 = b_count;
    run_burst(8'h33, 32'h500, 0, 2, 2'b01, -1);
    wait_b(b0 + 1);
    repeat (4) step();
    chk("post_reset_b_count", 128'(b_count - b0), 128'd1);
    chk("post_reset_bid", 128'(obs_bid), 128'h33);
    exp_q = '{32'h500};
    check_obs("post_reset");

    // Random bursts; the next AW is offered while the previous B may still be pending
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2:    burst = 2'b00;
        3, 4, 5, 6: burst = 2'b01;
        7, 8:       burst = 2'b10;
        default:    burst = 2'b11;
      endcase
      size = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      if (burst == 2'b10 && $urandom_range(0, 5) != 0) begin
        case ($urandom_range(0, 3))
          0: len = 1;
          1: len = 3;
          2: len = 7;
          default: len = 15;
        endcase
      end else begin
        len = $urandom_range(0, 15);
      end
      addr = $urandom;
      if (burst == 2'b10 && $urandom_range(0, 5) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
      bad = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1;
      run_burst(8'($urandom), addr, len, size, burst, bad);
    end
    b0 = b_count;
    repeat (40) step();
    chk("final_idle_awready", 128'(awready), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
